// File: rtl/gray_counter_pkg.sv
// Shared constants and helpers for the Gray-code LED counter controller.
package gray_counter_pkg;

    localparam int BTN_STEP = 0;
    localparam int BTN_MODE = 1;
    localparam int BTN_CLR  = 2;
    localparam int BTN_DIR  = 3;
    localparam int BTN_N    = 4;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability-counter debouncer with a
// one-cycle registered pulse on each debounced press.
module btn_debounce #(
    parameter int DB_BITS = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic PB,
    output logic PB_state,
    output logic PB_press
);

    logic               sync1_reg;
    logic               sync2_reg;
    logic               state_reg;
    logic               press_reg;
    logic [DB_BITS-1:0] dcnt_reg;
    logic               differ;
    logic               settled;

    assign differ  = (sync2_reg != state_reg);
    assign settled = &dcnt_reg;

    // Any sample that agrees with the current state restarts the stability count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            state_reg <= 1'b0;
            press_reg <= 1'b0;
            dcnt_reg  <= '0;
        end else begin
            sync1_reg <= PB;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            if (!differ) begin
                dcnt_reg <= '0;
            end else if (settled) begin
                state_reg <= sync2_reg;
                press_reg <= sync2_reg;
                dcnt_reg  <= '0;
            end else begin
                dcnt_reg <= dcnt_reg + DB_BITS'(1);
            end
        end
    end

    assign PB_state = state_reg;
    assign PB_press = press_reg;

endmodule

// File: rtl/gray_counter_ctl.sv
// Gray-coded LED counter with auto (prescaler) or manual (debounced step)
// advance, up/down direction, synchronous clear and an activity indicator.
module gray_counter_ctl #(
    parameter int WIDTH    = 10,
    parameter int DIV_BITS = 23,
    parameter int DB_BITS  = 16,
    parameter int ACT_N    = 3,
    parameter int ACT_LOW  = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [3:0]       BTTN,
    output logic [WIDTH-1:0] LEDS,
    output logic [ACT_N-1:0] ACT_LED,
    output logic             DIR,
    output logic             MODE
);

    import gray_counter_pkg::*;

    logic [BTN_N-1:0]    btn_state;
    logic [BTN_N-1:0]    btn_press;
    logic [DIV_BITS-1:0] div_reg;
    logic [ACT_N-1:0]    act_reg;
    logic [ACT_N-1:0]    act_rev;
    logic [WIDTH-1:0]    cnt_reg;
    logic [WIDTH-1:0]    cnt_next;
    logic                dir_reg;
    logic                tick;
    logic                en;
    logic                unused_btn;

    for (genvar gi = 0; gi < BTN_N; gi++) begin : g_btn
        btn_debounce #(
            .DB_BITS (DB_BITS)
        ) u_debounce (
            .CLK      (CLK),
            .RST      (RST),
            .PB       (BTTN[gi]),
            .PB_state (btn_state[gi]),
            .PB_press (btn_press[gi])
        );
    end

    // Step and direction act on edges only; mode and clear act on levels.
    assign unused_btn = ^{btn_state[BTN_STEP], btn_state[BTN_DIR],
                          btn_press[BTN_MODE], btn_press[BTN_CLR]};

    assign tick = &div_reg;
    assign en   = btn_state[BTN_MODE] ? btn_press[BTN_STEP] : tick;

    always_comb begin
        cnt_next = cnt_reg;
        if (btn_state[BTN_CLR]) begin
            cnt_next = '0;
        end else if (en) begin
            cnt_next = (dir_reg == DIR_DOWN) ? cnt_reg - WIDTH'(1) : cnt_reg + WIDTH'(1);
        end
    end

    // A direction toggle in the same cycle as a count affects only later counts.
    always_ff @(posedge CLK) begin
        if (RST) begin
            div_reg <= '0;
            act_reg <= '0;
            cnt_reg <= '0;
            dir_reg <= DIR_UP;
        end else begin
            div_reg <= div_reg + DIV_BITS'(1);
            cnt_reg <= cnt_next;
            if (tick) begin
                act_reg <= act_reg + ACT_N'(1);
            end
            if (btn_press[BTN_DIR]) begin
                dir_reg <= ~dir_reg;
            end
        end
    end

    for (genvar gi = 0; gi < ACT_N; gi++) begin : g_act_rev
        assign act_rev[gi] = act_reg[ACT_N-1-gi];
    end

    assign ACT_LED = (ACT_LOW != 0) ? ~act_rev : act_rev;
    assign LEDS    = WIDTH'(bin2gray(32'(cnt_reg)));
    assign DIR     = dir_reg;
    assign MODE    = btn_state[BTN_MODE];

endmodule

// File: tb/tb_gray_counter_ctl.sv
// Self-checking bench for gray_counter_ctl: directed vectors, hand sequences
// and random buttons compared every cycle against a behavioural model.
module tb_gray_counter_ctl;

    localparam int WIDTH    = 4;
    localparam int DIV_BITS = 3;
    localparam int DB_BITS  = 2;
    localparam int ACT_N    = 3;
    localparam int ACT_LOW  = 1;
    localparam int DBW      = 1 << DB_BITS;
    localparam int TICKP    = 1 << DIV_BITS;
    localparam int CMOD     = 1 << WIDTH;
    localparam int AMOD     = 1 << ACT_N;

    logic             CLK  = 1'b0;
    logic             RST  = 1'b1;
    logic [3:0]       BTTN = 4'h0;
    logic [WIDTH-1:0] LEDS;
    logic [ACT_N-1:0] ACT_LED;
    logic             DIR;
    logic             MODE;

    gray_counter_ctl #(
        .WIDTH    (WIDTH),
        .DIV_BITS (DIV_BITS),
        .DB_BITS  (DB_BITS),
        .ACT_N    (ACT_N),
        .ACT_LOW  (ACT_LOW)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .BTTN    (BTTN),
        .LEDS    (LEDS),
        .ACT_LED (ACT_LED),
        .DIR     (DIR),
        .MODE    (MODE)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            if (bad < 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] gray_of(input int c);
        return 32'(c ^ (c >> 1));
    endfunction

    function automatic logic [31:0] act_led_of(input int a);
        logic [ACT_N-1:0] r;
        for (int i = 0; i < ACT_N; i++) r[i] = a[ACT_N-1-i];
        if (ACT_LOW != 0) r = ~r;
        return 32'(r);
    endfunction

    // Reference model: a button's level follows the raw input once the last
    // DBW samples, seen through the two-stage synchroniser delay, all disagree.
    int       m_cnt, m_act, m_cyc;
    bit       m_dir, m_tick, m_en, m_all;
    bit       m_db    [4];
    bit       m_press [4];
    bit [15:0] m_hist [4];
    bit       mdl_chk = 1'b0;

    always @(posedge CLK) begin
        if (RST) begin
            m_cnt = 0; m_act = 0; m_cyc = 0; m_dir = 1'b0;
            for (int b = 0; b < 4; b++) begin
                m_db[b] = 1'b0; m_press[b] = 1'b0; m_hist[b] = '0;
            end
        end else begin
            m_tick = (m_cyc % TICKP) == TICKP - 1;
            m_en   = m_db[1] ? m_press[0] : m_tick;
            if (m_db[2]) m_cnt = 0;
            else if (m_en) m_cnt = m_dir ? (m_cnt + CMOD - 1) % CMOD : (m_cnt + 1) % CMOD;
            if (m_press[3]) m_dir = !m_dir;
            if (m_tick) m_act = (m_act + 1) % AMOD;
            m_cyc++;
            for (int b = 0; b < 4; b++) begin
                m_hist[b] = {m_hist[b][14:0], BTTN[b]};
                m_all = 1'b1;
                for (int k = 2; k < 2 + DBW; k++)
                    if (m_hist[b][k] == m_db[b]) m_all = 1'b0;
                m_press[b] = 1'b0;
                if (m_all) begin
                    m_db[b]    = !m_db[b];
                    m_press[b] = m_db[b];
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (mdl_chk) begin
            check("mdl_leds", 32'(LEDS), gray_of(m_cnt));
            check("mdl_act_led", 32'(ACT_LED), act_led_of(m_act));
            check("mdl_dir", 32'(DIR), 32'(m_dir));
            check("mdl_mode", 32'(MODE), 32'(m_db[1]));
        end
    end

    typedef struct {
        logic [3:0]       bttn;
        int               cycles;
        logic [WIDTH-1:0] leds;
        logic [ACT_N-1:0] act_led;
        logic             dir;
        logic             mode;
    } vec_t;

    vec_t vecs [4];

    task automatic run(input logic [3:0] b, input int n);
        BTTN = b;
        repeat (n) @(negedge CLK);
    endtask

    task automatic press(input logic [3:0] base);
        run(base | 4'h1, 8);
        run(base, 8);
    endtask

    initial begin
        // Auto counting from reset release: one tick every 8 cycles.
        vecs[0] = '{4'h0, 8,  4'b0001, 3'b011, 1'b0, 1'b0};
        vecs[1] = '{4'h0, 32, 4'b0111, 3'b010, 1'b0, 1'b0};
        vecs[2] = '{4'h0, 80, 4'b1000, 3'b000, 1'b0, 1'b0};
        vecs[3] = '{4'h0, 8,  4'b0000, 3'b111, 1'b0, 1'b0};

        RST = 1'b1; BTTN = 4'h0;
        repeat (2) @(negedge CLK);
        check("rst_leds", 32'(LEDS), 32'(4'b0000));
        check("rst_act_led", 32'(ACT_LED), 32'(3'b111));
        check("rst_dir", 32'(DIR), 32'(0));
        check("rst_mode", 32'(MODE), 32'(0));
        mdl_chk = 1'b1;
        RST = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run(vecs[i].bttn, vecs[i].cycles);
            check("vec_leds", 32'(LEDS), 32'(vecs[i].leds));
            check("vec_act_led", 32'(ACT_LED), 32'(vecs[i].act_led));
            check("vec_dir", 32'(DIR), 32'(vecs[i].dir));
            check("vec_mode", 32'(MODE), 32'(vecs[i].mode));
        end

        for (int i = 0; i < 12; i++) begin
            BTTN = (i % 2 == 0) ? 4'h2 : 4'h0;
            @(negedge CLK);
            check("glitch_mode", 32'(MODE), 32'(0));
        end
        BTTN = 4'h2;
        for (int k = 1; k <= 6; k++) begin
            @(negedge CLK);
            check("mode_edge", 32'(MODE), 32'(k == 6));
        end

        run(4'h6, 8); run(4'h2, 8);
        for (int i = 0; i < 3; i++) press(4'h2);
        check("manual_leds", 32'(LEDS), 32'(4'b0010));

        run(4'h6, 8); run(4'h2, 8);
        check("clr_leds", 32'(LEDS), 32'(4'b0000));
        run(4'hA, 8); run(4'h2, 8);
        check("dir_down", 32'(DIR), 32'(1));
        press(4'h2);
        check("wrap_down", 32'(LEDS), 32'(4'b1000));
        press(4'h2);
        check("down_14", 32'(LEDS), 32'(4'b1001));

        run(4'h6, 8);
        check("clr_hold", 32'(LEDS), 32'(4'b0000));
        press(4'h6); press(4'h6);
        check("clr_vs_step", 32'(LEDS), 32'(4'b0000));
        run(4'h4, 24);
        check("clr_vs_tick", 32'(LEDS), 32'(4'b0000));
        run(4'h6, 8); run(4'h2, 8);
        check("clr_release", 32'(LEDS), 32'(4'b0000));
        press(4'h2);
        check("after_clr_down", 32'(LEDS), 32'(4'b1000));
        run(4'hA, 8); run(4'h2, 8);
        check("dir_up", 32'(DIR), 32'(0));
        run(4'h6, 8); run(4'h2, 8); press(4'h2);
        check("after_clr_up", 32'(LEDS), 32'(4'b0001));

        for (int n = 0; n < 400; n++) begin
            BTTN = 4'($urandom) & (($urandom_range(0, 3) == 0) ? 4'hF : 4'hB);
            repeat ($urandom_range(1, 12)) @(negedge CLK);
        end

        BTTN = 4'h3; RST = 1'b1;
        @(negedge CLK);
        check("midrst_leds", 32'(LEDS), 32'(4'b0000));
        check("midrst_act_led", 32'(ACT_LED), 32'(3'b111));
        check("midrst_dir", 32'(DIR), 32'(0));
        check("midrst_mode", 32'(MODE), 32'(0));
        RST = 1'b0;
        repeat (10) @(negedge CLK);
        check("held_step_leds", 32'(LEDS), 32'(4'b0001));
        check("held_step_mode", 32'(MODE), 32'(1));
        check("held_step_act", 32'(ACT_LED), 32'(3'b011));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gray_counter_ctl.md
Name: gray_counter_ctl

Overview:
Parametrised, single-clock successor to the board LED counter. It drives a WIDTH-bit Gray-coded LED counter and an ACT_N-bit activity indicator. The counter runs in two modes: auto (prescaler tick) or manual (debounced step button). It also provides up/down direction and a synchronous clear. All derived clocks are replaced by clock enables, and all button handling is debounced in the CLK domain.

Parameters:
WIDTH, 10, counter/LED width (>=2)
DIV_BITS, 23, prescaler width; tick period = 2^DIV_BITS cycles
DB_BITS, 16, debounce stability counter width; stable time = 2^DB_BITS cycles
ACT_N, 3, activity indicator width
ACT_LOW, 1, 1 = ACT_LED driven as current sinks (inverted)

Ports:
CLK  in  1  system clock; all logic on rising edge
RST  in  1  reset, synchronous, active-high
BTTN  in  4  raw async buttons, active-high pressed: [0] step, [1] manual-mode level, [2] clear level, [3] direction toggle
LEDS  out  WIDTH  Gray code of counter: cnt ^ (cnt >> 1)
ACT_LED  out  ACT_N  activity counter, bit-reversed, inverted if ACT_LOW
DIR  out  1  0 = up, 1 = down
MODE  out  1  0 = auto, 1 = manual

Behaviour:
- Reset (RST=1 at edge): cnt=0, act=0, div=0, DIR=0; all sync flops, debounce states, counters and pulses cleared. Outputs after reset: LEDS=0, ACT_LED=all-ones if ACT_LOW else 0, DIR=0, MODE=0. Reset mid-operation takes effect at that edge and overrides everything.
- Sync: two-flop synchroniser per button.
- Debounce, per button:
  - sync!=state: dcnt increments.
  - sync!=state and dcnt all-ones: state<=sync, dcnt<=0.
  - sync==state: dcnt<=0.
  - Any bounce restarts the count.
  - State changes on the (2^DB_BITS+2)th edge after a raw change, counting the first capturing edge as 1.
  - press = registered one-cycle pulse on state 0->1.
- Prescaler: div free-running, wraps mod 2^DIV_BITS. tick=1 for one cycle when div==all-ones.
- MODE = debounced BTTN[1] level.
- Count enable: en = MODE ? press[0] : tick. press[0] is ignored in auto mode; tick is ignored in manual mode.
- Counter update, priority order:
  - Debounced BTTN[2]=1: cnt<=0, held for as long as it is asserted.
  - Else en=1: cnt<=cnt+1 (DIR=0) or cnt-1 (DIR=1), modulo 2^WIDTH (15->0 up, 0->15 down for WIDTH=4).
- DIR toggles on press[3]. If the toggle and en fall in the same cycle, the count uses the old DIR; the new DIR applies from the next count.
- LEDS is combinational from the cnt register; it changes the cycle after the enabling edge.
- act increments on every tick regardless of MODE, clear or DIR, and wraps mod 2^ACT_N. ACT_LED = {act[0],...,act[ACT_N-1]}, inverted when ACT_LOW=1.
- Button held through reset: after release it is seen as a fresh press once debounced, so a step occurs in manual mode.

Decomposition:
- Package gray_counter_pkg:
  - button index constants BTN_STEP=0, BTN_MODE=1, BTN_CLR=2, BTN_DIR=3
  - bin2gray function
  - DIR_UP/DIR_DOWN constants
- Sub-module btn_debounce (parameter DB_BITS; ports CLK, RST, PB, PB_state, PB_press), instantiated 4x.

Test Plan (WIDTH=4, DIV_BITS=3, DB_BITS=2, ACT_N=3, ACT_LOW=1):
- Reset: RST=1 for 2 cycles, BTTN=0 -> LEDS=0000, ACT_LED=111, DIR=0, MODE=0. RST=1 asserted mid-count -> same values after that edge.
- Auto count: idle buttons -> cnt increments every 8 cycles. cnt=5 gives LEDS=0111; cnt=15 gives 1000; 16 ticks wrap to 0000. After the first tick, ACT_LED=011.
- Debounce: BTTN[1] toggled as 1-cycle glitches every 2 cycles -> MODE stays 0. Held high -> MODE=1 on the 6th edge.
- Manual step: MODE=1, three clean BTTN[0] presses -> cnt=3, LEDS=0010. Prescaler ticks during this do not advance cnt; ACT_LED still advances.
- Direction/wrap: cnt=0, press BTTN[3] -> DIR=1. Next step -> cnt=15, LEDS=1000. Next step -> cnt=14, LEDS=1001.
- Clear priority: debounced BTTN[2]=1 while steps and ticks occur -> LEDS stays 0000. After release, the first step -> 0001 (up) or 1000 (down).
